// File: rtl/z80_exec_ld_reg_ixiy_pkg.sv
// z80_exec_ld_reg_ixiy_pkg: shared constants, state encoding and decode helper for LD r,(IX/IY+d)
package z80_exec_ld_reg_ixiy_pkg;
  localparam logic [3:0] REG_IX = 4'd10;
  localparam logic [3:0] REG_IY = 4'd11;
  localparam logic [7:0] PREFIX_IX = 8'hDD;
  localparam logic [7:0] PREFIX_IY = 8'hFD;
  localparam int OP_R_MSB = 5;
  localparam int OP_R_LSB = 3;
  localparam logic [2:0] INSN_LEN = 3'd3;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FETCH0 = 3'd1,
    S_FETCH1 = 3'd2,
    S_FETCH2 = 3'd3,
    S_READ = 3'd4,
    S_WB = 3'd5
  } state_t;
  // r == 6 would be the (HL) slot, which this encoding does not cover
  function automatic logic legal_op(input logic [7:0] op);
    return op[7:6] == 2'b01 && op[2:0] == 3'b110 && op[OP_R_MSB:OP_R_LSB] != 3'd6;
  endfunction
endpackage

// File: rtl/z80_exec_ld_reg_ixiy_if.sv
// z80_exec_ld_reg_ixiy_if: held-request memory read bus
interface z80_exec_ld_reg_ixiy_if;
  logic [15:0] mem_addr;
  logic mem_rd;
  logic [7:0] mem_rdata;
  logic mem_ready;
  modport master(output mem_addr, mem_rd, input mem_rdata, mem_ready);
  modport slave(input mem_addr, mem_rd, output mem_rdata, mem_ready);
endinterface

// File: rtl/z80_exec_ld_reg_ixiy_mem_rd_port.sv
// z80_exec_ld_reg_ixiy_mem_rd_port: registered read request held until ready, plus captured read data
module z80_exec_ld_reg_ixiy_mem_rd_port (
  input logic clk,
  input logic reset,
  input logic issue,
  input logic [15:0] issue_addr,
  z80_exec_ld_reg_ixiy_if.master bus,
  output logic ack,
  output logic [7:0] data
);
  assign ack = bus.mem_rd && bus.mem_ready;
  // a new request issued on the completing edge keeps mem_rd high across accesses
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.mem_rd <= 1'b0;
      bus.mem_addr <= '0;
      data <= '0;
    end else begin
      if (ack) data <= bus.mem_rdata;
      if (issue) begin
        bus.mem_rd <= 1'b1;
        bus.mem_addr <= issue_addr;
      end else if (ack) bus.mem_rd <= 1'b0;
    end
  end
endmodule

// File: rtl/z80_exec_ld_reg_ixiy.sv
// z80_exec_ld_reg_ixiy: multi-cycle sequencer for LD r,(IX/IY+d) publishing a Z80FI retirement record
module z80_exec_ld_reg_ixiy
  import z80_exec_ld_reg_ixiy_pkg::*;
(
  input logic clk,
  input logic reset,
  input logic start,
  input logic [15:0] pc_in,
  output logic busy,
  output logic illegal,
  z80_exec_ld_reg_ixiy_if.master bus,
  output logic [3:0] reg_rnum,
  input logic [15:0] reg_rdata,
  output logic reg_wr,
  output logic [3:0] reg_wnum,
  output logic [7:0] reg_wdata,
  output logic z80fi_valid,
  output logic [31:0] z80fi_insn,
  output logic [2:0] z80fi_insn_len,
  output logic [15:0] z80fi_pc_rdata,
  output logic [15:0] z80fi_pc_wdata,
  output logic [3:0] z80fi_reg1_rnum,
  output logic [15:0] z80fi_reg1_rdata,
  output logic [15:0] z80fi_mem_raddr,
  output logic [7:0] z80fi_mem_rdata,
  output logic [3:0] z80fi_reg_wnum,
  output logic [7:0] z80fi_reg_wdata
);
  state_t state;
  logic [15:0] pc, base, issue_addr;
  logic [7:0] prefix, opcode, disp;
  logic ack, issue, pfx_ok, op_ok;
  assign pfx_ok = bus.mem_rdata == PREFIX_IX || bus.mem_rdata == PREFIX_IY;
  assign op_ok = legal_op(bus.mem_rdata);
  // the next access is issued on the edge that completes the current one
  assign issue = (state == S_IDLE && start) ||
                 (ack && (state == S_FETCH0 ? pfx_ok : state == S_FETCH1 ? op_ok : state == S_FETCH2));
  assign issue_addr = state == S_IDLE ? pc_in : state == S_FETCH0 ? pc + 16'd1 :
                      state == S_FETCH1 ? pc + 16'd2 : reg_rdata + {8'h00, bus.mem_rdata};
  z80_exec_ld_reg_ixiy_mem_rd_port u_port (
    .clk(clk),
    .reset(reset),
    .issue(issue),
    .issue_addr(issue_addr),
    .bus(bus),
    .ack(ack),
    .data(reg_wdata)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      busy <= 1'b0;
      illegal <= 1'b0;
      reg_wr <= 1'b0;
      z80fi_valid <= 1'b0;
      pc <= '0;
      base <= '0;
      prefix <= '0;
      opcode <= '0;
      disp <= '0;
      reg_rnum <= '0;
      reg_wnum <= '0;
      z80fi_insn <= '0;
      z80fi_insn_len <= '0;
      z80fi_pc_rdata <= '0;
      z80fi_pc_wdata <= '0;
      z80fi_reg1_rnum <= '0;
      z80fi_reg1_rdata <= '0;
      z80fi_mem_raddr <= '0;
      z80fi_mem_rdata <= '0;
      z80fi_reg_wnum <= '0;
      z80fi_reg_wdata <= '0;
    end else begin
      illegal <= 1'b0;
      reg_wr <= 1'b0;
      z80fi_valid <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          pc <= pc_in;
          busy <= 1'b1;
          state <= S_FETCH0;
        end
        S_FETCH0: if (ack) begin
          prefix <= bus.mem_rdata;
          illegal <= !pfx_ok;
          busy <= pfx_ok;
          state <= pfx_ok ? S_FETCH1 : S_IDLE;
        end
        S_FETCH1: if (ack) begin
          opcode <= bus.mem_rdata;
          reg_rnum <= prefix[5] ? REG_IY : REG_IX;
          illegal <= !op_ok;
          busy <= op_ok;
          state <= op_ok ? S_FETCH2 : S_IDLE;
        end
        S_FETCH2: if (ack) begin
          disp <= bus.mem_rdata;
          base <= reg_rdata;
          state <= S_READ;
        end
        S_READ: if (ack) begin
          reg_wr <= 1'b1;
          reg_wnum <= {1'b0, opcode[OP_R_MSB:OP_R_LSB]};
          z80fi_valid <= 1'b1;
          z80fi_insn <= {8'h00, disp, opcode, prefix};
          z80fi_insn_len <= INSN_LEN;
          z80fi_pc_rdata <= pc;
          z80fi_pc_wdata <= pc + 16'd3;
          z80fi_reg1_rnum <= reg_rnum;
          z80fi_reg1_rdata <= base;
          z80fi_mem_raddr <= bus.mem_addr;
          z80fi_mem_rdata <= bus.mem_rdata;
          z80fi_reg_wnum <= {1'b0, opcode[OP_R_MSB:OP_R_LSB]};
          z80fi_reg_wdata <= bus.mem_rdata;
          state <= S_WB;
        end
        S_WB: begin
          busy <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_z80_exec_ld_reg_ixiy.sv
// tb_z80_exec_ld_reg_ixiy: randomized self-checking bench against a per-instruction reference model
module tb_z80_exec_ld_reg_ixiy;
  import z80_exec_ld_reg_ixiy_pkg::*;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [15:0] pc_in = '0;
  logic busy, illegal, reg_wr, z80fi_valid;
  logic [3:0] reg_rnum, reg_wnum, z80fi_reg1_rnum, z80fi_reg_wnum;
  logic [15:0] reg_rdata, z80fi_pc_rdata, z80fi_pc_wdata, z80fi_reg1_rdata, z80fi_mem_raddr;
  logic [7:0] reg_wdata, z80fi_mem_rdata, z80fi_reg_wdata;
  logic [31:0] z80fi_insn;
  logic [2:0] z80fi_insn_len;
  logic [122:0] trace_now, last_trace = '0;
  logic [7:0] mem [65536];
  logic [15:0] regs [16];
  logic [15:0] addr_q [$];
  int compared = 0, mismatched = 0, cyc = 0, valid_cnt = 0, wr_cnt = 0, wait_total = 0;
  int fixed_waits = 0, hold_after = -1, last_lat = 0, last_valid_cyc = 0;
  bit rand_waits = 0, noise = 0;

  z80_exec_ld_reg_ixiy_if bus();

  z80_exec_ld_reg_ixiy dut (
    .clk(clk), .reset(reset), .start(start), .pc_in(pc_in), .busy(busy), .illegal(illegal),
    .bus(bus), .reg_rnum(reg_rnum), .reg_rdata(reg_rdata), .reg_wr(reg_wr), .reg_wnum(reg_wnum),
    .reg_wdata(reg_wdata), .z80fi_valid(z80fi_valid), .z80fi_insn(z80fi_insn),
    .z80fi_insn_len(z80fi_insn_len), .z80fi_pc_rdata(z80fi_pc_rdata), .z80fi_pc_wdata(z80fi_pc_wdata),
    .z80fi_reg1_rnum(z80fi_reg1_rnum), .z80fi_reg1_rdata(z80fi_reg1_rdata),
    .z80fi_mem_raddr(z80fi_mem_raddr), .z80fi_mem_rdata(z80fi_mem_rdata),
    .z80fi_reg_wnum(z80fi_reg_wnum), .z80fi_reg_wdata(z80fi_reg_wdata)
  );

  assign reg_rdata = regs[reg_rnum];
  assign trace_now = {z80fi_insn, z80fi_insn_len, z80fi_pc_rdata, z80fi_pc_wdata, z80fi_reg1_rnum,
                      z80fi_reg1_rdata, z80fi_mem_raddr, z80fi_mem_rdata, z80fi_reg_wnum, z80fi_reg_wdata};

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end
  initial forever begin
    @(negedge clk);
    if (z80fi_valid) valid_cnt++;
    if (reg_wr) wr_cnt++;
  end

  // memory responder: per-access wait states, optional idle noise on mem_ready
  initial begin
    int cnt, cur;
    cnt = 0;
    cur = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_rd && !(hold_after >= 0 && addr_q.size() >= hold_after)) begin
        if (cnt >= (rand_waits ? cur : fixed_waits)) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = mem[bus.mem_addr];
          addr_q.push_back(bus.mem_addr);
          cnt = 0;
          cur = $urandom_range(0, 3);
        end else begin
          bus.mem_ready = 1'b0;
          bus.mem_rdata = 8'($urandom);
          cnt++;
          wait_total++;
        end
      end else begin
        bus.mem_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.mem_rdata = 8'($urandom);
        if (!bus.mem_rd) cnt = 0;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1);
  end

  task automatic do_insn(input logic [15:0] pc, input logic [7:0] b0, b1, b2, data_in);
    logic [15:0] p1, p2, base, ea;
    logic [7:0] data;
    logic [122:0] exp;
    logic pfx_ok, legal;
    int n, w0, v0, r0, exp_n;
    p1 = pc + 16'd1;
    p2 = pc + 16'd2;
    pfx_ok = b0 == 8'hDD || b0 == 8'hFD;
    legal = pfx_ok && b1[7:6] == 2'b01 && b1[2:0] == 3'b110 && b1[5:3] != 3'd6;
    base = b0 == 8'hFD ? regs[REG_IY] : regs[REG_IX];
    ea = base + {8'h00, b2};
    mem[ea] = data_in;
    mem[pc] = b0;
    mem[p1] = b1;
    mem[p2] = b2;
    data = mem[ea];
    exp = {8'h00, b2, b1, b0, 3'd3, pc, pc + 16'd3, b0 == 8'hFD ? REG_IY : REG_IX, base, ea, data,
           1'b0, b1[5:3], data};
    addr_q.delete();
    w0 = wait_total;
    v0 = valid_cnt;
    r0 = wr_cnt;
    pc_in = pc;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    pc_in = 16'($urandom);
    n = 1;
    compared++;
    if (busy !== 1'b1 || bus.mem_rd !== 1'b1 || bus.mem_addr !== pc) begin
      mismatched++;
      $display("FAIL fetch0: busy=%b rd=%b addr=%h, expected 1 1 %h", busy, bus.mem_rd, bus.mem_addr, pc);
    end
    while (!(z80fi_valid === 1'b1 || illegal === 1'b1) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    last_lat = n;
    exp_n = (legal ? 5 : pfx_ok ? 3 : 2) + (wait_total - w0);
    compared++;
    if (n != exp_n) begin
      mismatched++;
      $display("FAIL latency pc=%h insn=%h%h%h: got %0d cycles, expected %0d", pc, b0, b1, b2, n, exp_n);
    end
    if (legal) begin
      compared++;
      if (illegal !== 1'b0 || reg_wr !== 1'b1 || busy !== 1'b1 || reg_wnum !== {1'b0, b1[5:3]} || reg_wdata !== data) begin
        mismatched++;
        $display("FAIL writeback: ill=%b wr=%b busy=%b wnum=%h wdata=%h, expected 0 1 1 %h %h",
                 illegal, reg_wr, busy, reg_wnum, reg_wdata, {1'b0, b1[5:3]}, data);
      end
      compared++;
      if (z80fi_insn !== exp[122:91] || z80fi_pc_wdata !== pc + 16'd3 || z80fi_mem_raddr !== ea) begin
        mismatched++;
        $display("FAIL trace_key: insn=%h pcw=%h raddr=%h, expected %h %h %h",
                 z80fi_insn, z80fi_pc_wdata, z80fi_mem_raddr, exp[122:91], pc + 16'd3, ea);
      end
      compared++;
      if (trace_now !== exp) begin
        mismatched++;
        $display("FAIL trace_all: got %h, expected %h", trace_now, exp);
      end
      compared++;
      if (addr_q.size() != 4 || addr_q[0] !== pc || addr_q[1] !== p1 || addr_q[2] !== p2 || addr_q[3] !== ea) begin
        mismatched++;
        $display("FAIL fetch_addrs: got %0d reads, expected 4 reads %h %h %h %h", addr_q.size(), pc, p1, p2, ea);
      end
      last_trace = exp;
      last_valid_cyc = cyc;
      @(posedge clk);
      #1;
      compared++;
      if (busy !== 1'b0 || z80fi_valid !== 1'b0 || reg_wr !== 1'b0 || valid_cnt != v0 + 1 || wr_cnt != r0 + 1) begin
        mismatched++;
        $display("FAIL after_retire: busy=%b valid=%b wr=%b pulses=%0d/%0d, expected 0 0 0 1/1",
                 busy, z80fi_valid, reg_wr, valid_cnt - v0, wr_cnt - r0);
      end
    end else begin
      compared++;
      if (illegal !== 1'b1 || z80fi_valid !== 1'b0 || reg_wr !== 1'b0 || busy !== 1'b0 || bus.mem_rd !== 1'b0) begin
        mismatched++;
        $display("FAIL illegal_exit: ill=%b valid=%b wr=%b busy=%b rd=%b, expected 1 0 0 0 0",
                 illegal, z80fi_valid, reg_wr, busy, bus.mem_rd);
      end
      compared++;
      if (trace_now !== last_trace) begin
        mismatched++;
        $display("FAIL trace_hold: got %h, expected %h", trace_now, last_trace);
      end
      @(posedge clk);
      #1;
      compared++;
      if (illegal !== 1'b0 || valid_cnt != v0 || wr_cnt != r0) begin
        mismatched++;
        $display("FAIL illegal_pulse: ill=%b pulses=%0d/%0d, expected 0 0/0", illegal, valid_cnt - v0, wr_cnt - r0);
      end
    end
  endtask

  task automatic test_reset;
    noise = 1;
    start = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if ({busy, illegal, bus.mem_rd, reg_wr, z80fi_valid} !== 5'b0 || bus.mem_addr !== 16'h0) begin
      mismatched++;
      $display("FAIL reset_strobes: busy/ill/rd/wr/valid=%b addr=%h, expected 00000 0000",
               {busy, illegal, bus.mem_rd, reg_wr, z80fi_valid}, bus.mem_addr);
    end
    compared++;
    if (reg_rnum !== 4'h0 || reg_wnum !== 4'h0 || reg_wdata !== 8'h00 || trace_now !== '0) begin
      mismatched++;
      $display("FAIL reset_regs: rnum=%h wnum=%h wdata=%h trace=%h, expected all zero", reg_rnum, reg_wnum, reg_wdata, trace_now);
    end
    start = 1'b0;
    reset = 1'b0;
    noise = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_zero_wait;
    rand_waits = 0;
    fixed_waits = 0;
    regs[REG_IX] = 16'h2000;
    do_insn(16'h0100, 8'hDD, 8'h46, 8'h05, 8'hA5);
    compared++;
    if (last_lat != 5 || z80fi_insn !== 32'h000546DD || z80fi_reg_wnum !== 4'h0 || z80fi_reg_wdata !== 8'hA5 ||
        z80fi_pc_wdata !== 16'h0103 || z80fi_mem_raddr !== 16'h2005) begin
      mismatched++;
      $display("FAIL zero_wait: lat=%0d insn=%h wnum=%h wdata=%h pcw=%h raddr=%h, expected 5 000546DD 0 A5 0103 2005",
               last_lat, z80fi_insn, z80fi_reg_wnum, z80fi_reg_wdata, z80fi_pc_wdata, z80fi_mem_raddr);
    end
  endtask

  task automatic test_iy_wait_wrap;
    fixed_waits = 2;
    regs[REG_IY] = 16'hFFF0;
    do_insn(16'h0200, 8'hFD, 8'h7E, 8'hF0, 8'h3C);
    compared++;
    if (last_lat != 13 || z80fi_mem_raddr !== 16'h00E0 || z80fi_reg_wnum !== 4'd7 || z80fi_reg1_rnum !== REG_IY) begin
      mismatched++;
      $display("FAIL iy_wait_wrap: lat=%0d raddr=%h wnum=%h r1=%h, expected 13 00E0 7 %h",
               last_lat, z80fi_mem_raddr, z80fi_reg_wnum, z80fi_reg1_rnum, REG_IY);
    end
    fixed_waits = 0;
  endtask

  task automatic test_illegal;
    do_insn(16'h0300, 8'hDD, 8'h76, 8'h00, 8'h11);
    compared++;
    if (last_lat != 3) begin
      mismatched++;
      $display("FAIL illegal_r6_cycle: got %0d, expected 3", last_lat);
    end
    do_insn(16'h0310, 8'hED, 8'h46, 8'h00, 8'h22);
    compared++;
    if (last_lat != 2) begin
      mismatched++;
      $display("FAIL illegal_prefix_cycle: got %0d, expected 2", last_lat);
    end
    do_insn(16'h0320, 8'hFD, 8'h47, 8'h01, 8'h33);
    do_insn(16'h0330, 8'hDD, 8'h86, 8'h01, 8'h44);
  endtask

  task automatic test_pc_wrap;
    regs[REG_IX] = 16'h4000;
    do_insn(16'hFFFE, 8'hDD, 8'h4E, 8'h03, 8'h99);
    compared++;
    if (z80fi_pc_wdata !== 16'h0001 || z80fi_pc_rdata !== 16'hFFFE) begin
      mismatched++;
      $display("FAIL pc_wrap: pcr=%h pcw=%h, expected FFFE 0001", z80fi_pc_rdata, z80fi_pc_wdata);
    end
  endtask

  task automatic test_back_to_back;
    int c1;
    regs[REG_IX] = 16'h0800;
    do_insn(16'h0500, 8'hDD, 8'h56, 8'h10, 8'h12);
    c1 = last_valid_cyc;
    do_insn(16'h0503, 8'hDD, 8'h5E, 8'h11, 8'h34);
    compared++;
    if (last_valid_cyc - c1 != 6) begin
      mismatched++;
      $display("FAIL back_to_back: period %0d cycles, expected 6", last_valid_cyc - c1);
    end
  endtask

  task automatic test_reset_mid;
    int n, v0, r0;
    regs[REG_IX] = 16'h1000;
    mem[16'h3000] = 8'hDD;
    mem[16'h3001] = 8'h46;
    mem[16'h3002] = 8'h10;
    addr_q.delete();
    hold_after = 3;
    v0 = valid_cnt;
    r0 = wr_cnt;
    pc_in = 16'h3000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (addr_q.size() < 3 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h1010 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL stalled_read: rd=%b addr=%h busy=%b, expected 1 1010 1", bus.mem_rd, bus.mem_addr, busy);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    last_trace = '0;
    compared++;
    if (bus.mem_rd !== 1'b0 || busy !== 1'b0 || reg_wr !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_mid: rd=%b busy=%b wr=%b, expected 0 0 0", bus.mem_rd, busy, reg_wr);
    end
    hold_after = -1;
    repeat (8) @(posedge clk);
    #1;
    compared++;
    if (valid_cnt != v0 || wr_cnt != r0 || trace_now !== '0) begin
      mismatched++;
      $display("FAIL reset_no_retire: pulses=%0d/%0d trace=%h, expected 0/0 0", valid_cnt - v0, wr_cnt - r0, trace_now);
    end
    do_insn(16'h3000, 8'hDD, 8'h46, 8'h10, 8'h5A);
  endtask

  task automatic test_random;
    rand_waits = 1;
    noise = 1;
    for (int i = 0; i < 60; i++) begin
      logic [7:0] b0, b1;
      int k;
      k = $urandom_range(0, 9);
      b0 = k < 4 ? 8'hDD : k < 8 ? 8'hFD : 8'($urandom);
      k = $urandom_range(0, 9);
      b1 = k < 8 ? {2'b01, 3'($urandom), 3'b110} : 8'($urandom);
      regs[REG_IX] = 16'($urandom);
      regs[REG_IY] = 16'($urandom);
      do_insn(16'($urandom), b0, b1, 8'($urandom), 8'($urandom));
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
    test_reset();
    test_zero_wait();
    test_iy_wait_wrap();
    test_illegal();
    test_pc_wrap();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/z80_exec_ld_reg_ixiy.md
# z80_exec_ld_reg_ixiy

Multi-cycle sequencer for the Z80 8-bit load group instruction LD r, (IX/IY + d).
- Fetches the three instruction bytes, reads IX or IY, reads the addressed memory byte and writes it to register r.
- Publishes the retirement record on the Z80FI trace port, so the existing LD r,(IX/IY+d) insn spec checks it.
- Sits between the core's memory bus, the register file and the formal harness.

## Interface
Parameters: none.

Ports:
- clk  in  1  sole clock, all state on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin execution at pc_in; sampled in IDLE only
- pc_in  in  16  address of prefix byte
- busy  out  1  high from the cycle after start until the retire cycle (inclusive)
- illegal  out  1  one-cycle pulse: fetched bytes do not encode this instruction
- mem_addr  out  16  bus read address
- mem_rd  out  1  read request
- mem_rdata  in  8  read data, valid when mem_ready
- mem_ready  in  1  completes the current read
- reg_rnum  out  4  register file read select
- reg_rdata  in  16  combinational read data
- reg_wr  out  1  register write strobe
- reg_wnum  out  4  register write select
- reg_wdata  out  8  register write data
- z80fi_valid  out  1  retirement pulse
- z80fi_insn  out  32  {8'h00, d, opcode, prefix}
- z80fi_insn_len  out  3  always 3 at retire
- z80fi_pc_rdata, z80fi_pc_wdata  out  16  pc_in; pc_in+3 mod 2^16
- z80fi_reg1_rnum  out  4; z80fi_reg1_rdata  out  16  IX/IY select and value
- z80fi_mem_raddr  out  16; z80fi_mem_rdata  out  8  data read
- z80fi_reg_wnum  out  4; z80fi_reg_wdata  out  8

## Operation
States: IDLE, FETCH0, FETCH1, FETCH2, READ, WB.

- **IDLE**
  - start=1 captures pc_in, then go to FETCH0.
  - Otherwise stay in IDLE.
- **FETCH0**
  - mem_addr=pc, mem_rd=1.
  - On mem_ready, capture the prefix byte.
  - Prefix not 8'hDD or 8'hFD: pulse illegal, go to IDLE.
- **FETCH1**
  - mem_addr=pc+1.
  - On mem_ready, capture the opcode.
  - Opcode[7:6]!=2'b01, or [2:0]!=3'b110, or r=opcode[5:3]==6: pulse illegal, go to IDLE.
- **FETCH2**
  - mem_addr=pc+2.
  - reg_rnum = prefix[5] ? REG_IY : REG_IX, driven for the whole state.
  - On mem_ready, capture d and reg_rdata together.
- **READ**
  - mem_addr = base + {8'h00, d}, mod 2^16.
  - d is zero-extended, by decision, to match the insn spec.
  - On mem_ready, capture the data byte.
- **WB**
  - reg_wr=1, reg_wnum={1'b0, r}, reg_wdata=data byte.
  - z80fi_valid=1; all z80fi_* fields loaded; go to IDLE.
- Address arithmetic is 16-bit with wrap: pc+1/pc+2/pc+3 and base+d all wrap at 16'hFFFF.
- Illegal exit: no reg_wr, no z80fi_valid, trace fields unchanged.
- Trace fields hold their last retired values until the next WB.

## Timing
- Reset values:
  - State IDLE.
  - busy, illegal, mem_rd, reg_wr, z80fi_valid: all 0.
  - mem_addr, reg_rnum, reg_wnum, reg_wdata: 0.
  - All z80fi_* fields: 0.
- Read handshake:
  - mem_rd and mem_addr are stable from state entry until the cycle mem_ready=1.
  - mem_rdata is sampled on that edge.
  - The state advances next cycle; mem_rd drops unless the next state also reads.
- Zero-wait latency:
  - start sampled at cycle 0; FETCH0..READ occupy cycles 1–4; WB (valid, reg_wr) at cycle 5.
  - Each wait cycle adds one cycle to the access it stalls.
- start while busy is ignored. Back-to-back: start may be asserted in the WB cycle's following IDLE, giving a 6-cycle period.
- mem_ready while mem_rd=0 is ignored.
- reset mid-instruction: next cycle is IDLE with all strobes 0. No partial reg_wr or z80fi_valid is emitted.

## Structure
- Shared constants come from the existing header z80.vh: REG_IX, REG_IY, register numbering.
- New include z80_ld_ixiy.vh holds:
  - prefix values 8'hDD/8'hFD;
  - opcode field positions;
  - state encodings (localparam, 3 bits).
- One sub-module is natural: z80_mem_rd_port. It is the held-request/ready handshake, with an addr/strobe register plus a capture register. It is reused by later multi-byte instructions.

## Test plan
- **Zero-wait retire**
  - Stimulus: pc=16'h0100, memory DD 46 05 at 0100..0102, IX=16'h2000, mem[2005]=8'hA5.
  - Response:
    - valid at cycle 5;
    - z80fi_insn=32'h000546DD;
    - reg_wnum=0, reg_wdata=A5;
    - z80fi_pc_wdata=0103;
    - mem_raddr=2005.
- **IY, wait states, wrap**
  - Stimulus: FD 7E F0 (r=7, A), IY=16'hFFF0, 2 wait cycles on each access.
  - Response: mem_raddr=16'h00E0, valid at cycle 13, reg_wnum=7.
- **Illegal decode**
  - Stimulus: DD 76 00 (r=6).
  - Response: illegal pulses in FETCH1; no reg_wr or z80fi_valid; busy low next cycle.
  - Stimulus: prefix 8'hED.
  - Response: illegal in FETCH0.
- **PC wrap**
  - Stimulus: pc=16'hFFFE.
  - Response: fetch addresses FFFE, FFFF, 0000; z80fi_pc_wdata=0001.
- **Reset mid-READ**
  - Stimulus: reset asserted during READ, with mem_ready held low.
  - Response: next cycle mem_rd=0, busy=0; no valid ever emitted.
  - Stimulus: new start after reset.
  - Response: retires normally.
- **Formal pairing**
  - Feed z80fi_* outputs to the existing LD r,(IX/IY+d) insn spec.
  - Response: spec_* predictions equal the observed reg_wnum, reg_wdata, mem_raddr and pc_wdata on every valid, under random wait states.
